tf_gen: RTL and testbench

- Twiddle-factor sequencer for one stage of the 16-point radix-2 delay-feedback (R2SDF) FFT pipeline.
- Counts incoming samples and produces the twiddle pair that the stage's complex twiddle multiplier consumes.
- Also produces the butterfly mode select for the same stage.
- One instance per stage; the STAGE parameter selects the twiddle stride and the block length. The INVERSE parameter conjugates twiddles for IFFT use.

---
 rtl/tf_gen.sv | 128 ++++++++++++
 tb/tb_tf_gen.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/tf_gen.sv
// -----------------------------------------------------------------------------
// tf_gen : twiddle-factor sequencer for one stage of a 16-point R2SDF FFT.
//
// Counts incoming samples within a 16-sample frame and produces, one cycle
// later, the twiddle pair for the stage's complex multiplier together with
// the butterfly-phase select.
//
// Parameters
//   STAGE   : pipeline stage 0..3; block length Ns = 16 >> STAGE
//   WNRD    : twiddle word width (signed, 7 fractional bits, 1.0 = +128)
//   INVERSE : 1 = conjugate twiddle (imaginary part negated) for IFFT
//
// Ports
//   clk            : clock, rising edge
//   rst_n          : asynchronous active-low reset
//   in_valid_i     : a sample enters the stage this cycle
//   frame_start_i  : with in_valid_i, marks sample 0 of a frame
//   out_valid_o    : registered copy of in_valid_i
//   wnr_re_o       : twiddle real part
//   wnr_im_o       : twiddle imaginary part
//   bf_sel_o       : 0 = delay-fill/rotate phase, 1 = butterfly phase
//   frame_last_o   : pulse aligned with the output for frame sample 15
// -----------------------------------------------------------------------------
module tf_gen #(
  parameter int STAGE   = 0,
  parameter int WNRD    = 9,
  parameter bit INVERSE = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid_i,
  input  logic                   frame_start_i,
  output logic                   out_valid_o,
  output logic signed [WNRD-1:0] wnr_re_o,
  output logic signed [WNRD-1:0] wnr_im_o,
  output logic                   bf_sel_o,
  output logic                   frame_last_o
);

  localparam int         NS       = 16 >> STAGE;
  localparam logic [3:0] BLK_MASK = 4'(NS - 1);
  localparam logic [3:0] HALF     = 4'(NS / 2);

  logic [3:0]            cnt_q, cnt_d;
  logic                  out_valid_q, out_valid_d;
  logic signed [WNRD-1:0] wnr_re_q, wnr_re_d;
  logic signed [WNRD-1:0] wnr_im_q, wnr_im_d;
  logic                  bf_sel_q, bf_sel_d;
  logic                  frame_last_q, frame_last_d;

  logic [3:0]        e_idx;
  logic [3:0]        blk_pos;
  logic              bf_phase;
  logic [2:0]        k_idx;
  logic signed [8:0] rom_re;
  logic signed [8:0] rom_im;
  logic signed [8:0] tw_im;

  // Effective index: a qualified frame_start forces position 0 (also used to
  // resynchronise mid-frame).
  assign e_idx    = frame_start_i ? 4'd0 : cnt_q;
  assign blk_pos  = e_idx & BLK_MASK;
  assign bf_phase = (blk_pos >= HALF);
  // Rotate phase uses W16^(b*2^STAGE); butterfly phase passes unity twiddle.
  assign k_idx    = bf_phase ? 3'd0 : 3'(blk_pos << STAGE);

  // W16^k = cos - j*sin, scaled by 128 and rounded to nearest.
  always_comb begin
    rom_re = 9'sd128;
    rom_im = 9'sd0;
    unique case (k_idx)
      3'd0: begin rom_re =  9'sd128; rom_im =  9'sd0;   end
      3'd1: begin rom_re =  9'sd118; rom_im = -9'sd49;  end
      3'd2: begin rom_re =  9'sd91;  rom_im = -9'sd91;  end
      3'd3: begin rom_re =  9'sd49;  rom_im = -9'sd118; end
      3'd4: begin rom_re =  9'sd0;   rom_im = -9'sd128; end
      3'd5: begin rom_re = -9'sd49;  rom_im = -9'sd118; end
      3'd6: begin rom_re = -9'sd91;  rom_im = -9'sd91;  end
      3'd7: begin rom_re = -9'sd118; rom_im = -9'sd49;  end
      default: begin rom_re = 9'sd128; rom_im = 9'sd0; end
    endcase
  end

  // +128 still fits in 9-bit signed, so conjugation never overflows.
  assign tw_im = INVERSE ? -rom_im : rom_im;

  always_comb begin
    cnt_d        = cnt_q;
    out_valid_d  = 1'b0;
    wnr_re_d     = wnr_re_q;
    wnr_im_d     = wnr_im_q;
    bf_sel_d     = bf_sel_q;
    frame_last_d = 1'b0;
    if (in_valid_i) begin
      cnt_d        = e_idx + 4'd1;  // wraps 15 -> 0
      out_valid_d  = 1'b1;
      wnr_re_d     = WNRD'(rom_re);
      wnr_im_d     = WNRD'(tw_im);
      bf_sel_d     = bf_phase;
      frame_last_d = (e_idx == 4'd15);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      out_valid_q  <= 1'b0;
      wnr_re_q     <= '0;
      wnr_im_q     <= '0;
      bf_sel_q     <= 1'b0;
      frame_last_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      out_valid_q  <= out_valid_d;
      wnr_re_q     <= wnr_re_d;
      wnr_im_q     <= wnr_im_d;
      bf_sel_q     <= bf_sel_d;
      frame_last_q <= frame_last_d;
    end
  end

  assign out_valid_o  = out_valid_q;
  assign wnr_re_o     = wnr_re_q;
  assign wnr_im_o     = wnr_im_q;
  assign bf_sel_o     = bf_sel_q;
  assign frame_last_o = frame_last_q;

endmodule

// File: tb/tb_tf_gen.sv
// -----------------------------------------------------------------------------
// tb_tf_gen : self-checking bench for tf_gen.
//
// Four instances (STAGE 0..3, INVERSE on for STAGE 2) share one stimulus
// stream. The reference model tracks the frame position and derives each
// twiddle from cos/sin of the angle 2*pi*b/Ns directly.
// -----------------------------------------------------------------------------
module tb_tf_gen;

  localparam int NI = 4;
  localparam int STAGES [NI] = '{0, 1, 2, 3};
  localparam bit INVS   [NI] = '{1'b0, 1'b0, 1'b1, 1'b0};

  logic clk;
  logic rst_n;
  logic in_valid;
  logic frame_start;

  logic              o_valid [NI];
  logic signed [8:0] o_re    [NI];
  logic signed [8:0] o_im    [NI];
  logic              o_bf    [NI];
  logic              o_last  [NI];

  int tests;
  int fails;
  int cyc;

  // model state
  int                mdl_pos;
  logic              exp_valid;
  logic              exp_last;
  logic signed [8:0] exp_re [NI];
  logic signed [8:0] exp_im [NI];
  logic              exp_bf [NI];

  tf_gen #(.STAGE(0), .WNRD(9), .INVERSE(1'b0)) u_s0 (
    .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid), .frame_start_i(frame_start),
    .out_valid_o(o_valid[0]), .wnr_re_o(o_re[0]), .wnr_im_o(o_im[0]),
    .bf_sel_o(o_bf[0]), .frame_last_o(o_last[0]));
  tf_gen #(.STAGE(1), .WNRD(9), .INVERSE(1'b0)) u_s1 (
    .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid), .frame_start_i(frame_start),
    .out_valid_o(o_valid[1]), .wnr_re_o(o_re[1]), .wnr_im_o(o_im[1]),
    .bf_sel_o(o_bf[1]), .frame_last_o(o_last[1]));
  tf_gen #(.STAGE(2), .WNRD(9), .INVERSE(1'b1)) u_s2 (
    .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid), .frame_start_i(frame_start),
    .out_valid_o(o_valid[2]), .wnr_re_o(o_re[2]), .wnr_im_o(o_im[2]),
    .bf_sel_o(o_bf[2]), .frame_last_o(o_last[2]));
  tf_gen #(.STAGE(3), .WNRD(9), .INVERSE(1'b0)) u_s3 (
    .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid), .frame_start_i(frame_start),
    .out_valid_o(o_valid[3]), .wnr_re_o(o_re[3]), .wnr_im_o(o_im[3]),
    .bf_sel_o(o_bf[3]), .frame_last_o(o_last[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Twiddle for frame position e in a stage: block position b = e mod Ns;
  // first half rotates by exp(-j*2*pi*b/Ns), second half uses 1.
  task automatic model_twiddle(input int stage, input bit inv, input int e,
                               output logic signed [8:0] re,
                               output logic signed [8:0] im,
                               output logic bf);
    int  ns;
    int  b;
    real ang;
    int  ri;
    int  ii;
    ns = 16 >> stage;
    b  = e % ns;
    if (b < ns / 2) begin
      ang = 2.0 * 3.14159265358979 * real'(b) / real'(ns);
      ri  = int'(128.0 * $cos(ang));
      ii  = int'(-128.0 * $sin(ang));
      bf  = 1'b0;
    end else begin
      ri = 128;
      ii = 0;
      bf = 1'b1;
    end
    if (inv) ii = -ii;
    re = 9'(ri);
    im = 9'(ii);
  endtask

  task automatic model_reset();
    mdl_pos   = 0;
    exp_valid = 1'b0;
    exp_last  = 1'b0;
    for (int i = 0; i < NI; i++) begin
      exp_re[i] = '0;
      exp_im[i] = '0;
      exp_bf[i] = 1'b0;
    end
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < NI; i++) begin
      tests++;
      assert (o_valid[i] === exp_valid) else begin
        fails++;
        $error("FAIL %s[s%0d] out_valid got %0b want %0b", tag, i, o_valid[i], exp_valid);
      end
      tests++;
      assert (o_last[i] === exp_last) else begin
        fails++;
        $error("FAIL %s[s%0d] frame_last got %0b want %0b", tag, i, o_last[i], exp_last);
      end
      tests++;
      assert (o_re[i] === exp_re[i]) else begin
        fails++;
        $error("FAIL %s[s%0d] wnr_re got %0d want %0d", tag, i, o_re[i], exp_re[i]);
      end
      tests++;
      assert (o_im[i] === exp_im[i]) else begin
        fails++;
        $error("FAIL %s[s%0d] wnr_im got %0d want %0d", tag, i, o_im[i], exp_im[i]);
      end
      tests++;
      assert (o_bf[i] === exp_bf[i]) else begin
        fails++;
        $error("FAIL %s[s%0d] bf_sel got %0b want %0b", tag, i, o_bf[i], exp_bf[i]);
      end
    end
  endtask

  // One clock of stimulus: drive at negedge, update model, check after edge.
  task automatic step(input logic v, input logic fs, input string tag);
    int e;
    @(negedge clk);
    in_valid    = v;
    frame_start = fs;
    e = -1;
    if (v) begin
      e = fs ? 0 : mdl_pos;
      mdl_pos = (e + 1) % 16;
      exp_valid = 1'b1;
      exp_last  = (e == 15);
      for (int i = 0; i < NI; i++)
        model_twiddle(STAGES[i], INVS[i], e, exp_re[i], exp_im[i], exp_bf[i]);
    end else begin
      exp_valid = 1'b0;
      exp_last  = 1'b0;
    end
    @(posedge clk);
    #1;
    cyc++;
    $display("[TB] cyc %0d %s v=%0b fs=%0b e=%0d s0=(%0d,%0d,bf%0b) last=%0b",
             cyc, tag, v, fs, e, o_re[0], o_im[0], o_bf[0], o_last[0]);
    check_all(tag);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    cyc   = 0;
    in_valid    = 1'b0;
    frame_start = 1'b0;
    rst_n       = 1'b0;
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // full-rate frame
    for (int n = 0; n < 16; n++) step(1'b1, n == 0, "full");
    step(1'b0, 1'b0, "idle");

    // alternating valid across one frame, frame_start with in_valid low ignored
    for (int n = 0; n < 32; n++) step(n % 2 == 0, n == 0 || n == 3, "alt");

    // mid-frame resynchronisation at the 6th valid sample
    for (int n = 0; n < 5; n++) step(1'b1, n == 0, "pre");
    step(1'b1, 1'b1, "resync");
    for (int n = 0; n < 16; n++) step(1'b1, 1'b0, "post");

    // asynchronous reset after sample 9
    for (int n = 0; n < 10; n++) step(1'b1, n == 0, "prerst");
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 1'b0, "after_rst");
    step(1'b1, 1'b0, "after_rst");

    // randomized traffic
    for (int n = 0; n < 400; n++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, "rand");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout cycles=%0d limit reached", cyc);
    $fatal(1, "timeout");
  end

endmodule
